// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit combinational ALU.
// Accepts one instruction at a time, reads operands from a 4-entry register
// file, drives the ALU, samples its result/carry after EXEC_WAIT cycles,
// writes the result back and presents it on a result handshake.
module alu_issue_ctrl #(
  parameter int EXEC_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_cout,
  output logic        carry_flag,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] instr_q;
  logic [15:0] rf [4];
  logic [3:0]  wait_cnt;

  // Instruction fields, always taken from the latched word
  logic [2:0]  f_opcode;
  logic [1:0]  f_rd;
  logic [1:0]  f_rs1;
  logic [1:0]  f_rs2;
  logic        f_imm_en;
  logic [5:0]  f_imm;

  assign f_opcode = instr_q[15:13];
  assign f_rd     = instr_q[12:11];
  assign f_rs1    = instr_q[10:9];
  assign f_rs2    = instr_q[8:7];
  assign f_imm_en = instr_q[6];
  assign f_imm    = instr_q[5:0];

  // Immediates are always two's complement; bit 5 fills the upper bits
  function automatic logic [15:0] sext_imm(input logic [5:0] imm);
    logic signed [5:0]  imm_s;
    logic signed [15:0] ext_s;
    imm_s = imm;
    ext_s = 16'(imm_s);
    return ext_s;
  endfunction

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; res_valid is always high in WB, so res_ready alone
  // completes the result handshake there
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid)      state_d = DECODE;
      DECODE:                        state_d = EXEC;
      EXEC:    if (wait_cnt == 4'd0) state_d = WB;
      WB:      if (res_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Datapath: instruction latch, operand drive, writeback and result hold.
  // ALU drive registers only change in DECODE, so they keep their last
  // values between instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= 16'h0000;
      for (int i = 0; i < 4; i++) rf[i] <= 16'h0000;
      wait_cnt   <= 4'd0;
      alu_x      <= 16'h0000;
      alu_y      <= 16'h0000;
      alu_op     <= 3'd0;
      alu_cin    <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= 16'h0000;
      res_cout   <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid) instr_q <= instr;
        end
        DECODE: begin
          // Operands are captured here, before any write to rd
          alu_x    <= rf[f_rs1];
          alu_y    <= f_imm_en ? sext_imm(f_imm) : rf[f_rs2];
          alu_op   <= f_opcode;
          alu_cin  <= carry_flag;
          wait_cnt <= 4'(EXEC_WAIT - 1);
        end
        EXEC: begin
          if (wait_cnt == 4'd0) begin
            rf[f_rd]  <= alu_out;
            res_data  <= alu_out;
            res_cout  <= alu_cout;
            res_valid <= 1'b1;
            // Only ADD updates the architectural carry
            if (f_opcode == 3'd0) carry_flag <= alu_cout;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WB: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with EXEC_WAIT=1 and one
// with EXEC_WAIT=4, each driving its own behavioural ALU model.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] instr;
  logic        res_ready;
  logic        vld;
  logic        sel;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A (EXEC_WAIT=1)
  logic        a_iv, a_ir, a_cin, a_cout, a_rv, a_rc, a_cf, a_busy;
  logic [15:0] a_x, a_y, a_out, a_rd;
  logic [2:0]  a_op;
  // Instance B (EXEC_WAIT=4)
  logic        b_iv, b_ir, b_cin, b_cout, b_rv, b_rc, b_cf, b_busy;
  logic [15:0] b_x, b_y, b_out, b_rd;
  logic [2:0]  b_op;

  assign a_iv = vld & ~sel;
  assign b_iv = vld & sel;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass X
  function automatic logic [16:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                         input logic [2:0] op, input logic cin);
    case (op)
      3'd0:    return {1'b0, x} + {1'b0, y} + {16'd0, cin};
      3'd1:    return {1'b0, x} - {1'b0, y};
      3'd2:    return {1'b0, x & y};
      3'd3:    return {1'b0, x | y};
      3'd4:    return {1'b0, x ^ y};
      default: return {1'b0, x};
    endcase
  endfunction

  assign {a_cout, a_out} = alu_f(a_x, a_y, a_op, a_cin);
  assign {b_cout, b_out} = alu_f(b_x, b_y, b_op, b_cin);

  alu_issue_ctrl #(.EXEC_WAIT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(a_iv), .instr_ready(a_ir), .instr(instr),
    .alu_x(a_x), .alu_y(a_y), .alu_op(a_op), .alu_cin(a_cin),
    .alu_out(a_out), .alu_cout(a_cout),
    .res_valid(a_rv), .res_ready(res_ready), .res_data(a_rd), .res_cout(a_rc),
    .carry_flag(a_cf), .busy(a_busy)
  );

  alu_issue_ctrl #(.EXEC_WAIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(b_iv), .instr_ready(b_ir), .instr(instr),
    .alu_x(b_x), .alu_y(b_y), .alu_op(b_op), .alu_cin(b_cin),
    .alu_out(b_out), .alu_cout(b_cout),
    .res_valid(b_rv), .res_ready(res_ready), .res_data(b_rd), .res_cout(b_rc),
    .carry_flag(b_cf), .busy(b_busy)
  );

  // Selected-instance view
  logic        m_ir, m_cin, m_rv, m_rc, m_cf, m_busy;
  logic [15:0] m_x, m_y, m_rd;
  logic [2:0]  m_op;
  assign m_ir   = sel ? b_ir   : a_ir;
  assign m_cin  = sel ? b_cin  : a_cin;
  assign m_rv   = sel ? b_rv   : a_rv;
  assign m_rc   = sel ? b_rc   : a_rc;
  assign m_cf   = sel ? b_cf   : a_cf;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_x    = sel ? b_x    : a_x;
  assign m_y    = sel ? b_y    : a_y;
  assign m_rd   = sel ? b_rd   : a_rd;
  assign m_op   = sel ? b_op   : a_op;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction, return cycles from accept edge to res_valid
  task automatic issue(input logic [15:0] w, output int n);
    int k;
    @(negedge clk);
    instr = w;
    vld   = 1'b1;
    k = 0;
    while (!m_ir && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!m_ir) check_val("accept_timeout", 32'(m_ir), 32'd1);
    @(posedge clk);
    #1 vld = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_rv && n < 40);
  endtask

  // Let the result handshake complete (res_ready high) and check IDLE
  task automatic finish_wb(input string tag);
    @(posedge clk);
    #1;
    check_val({tag, "_rv_drop"}, 32'(m_rv), 32'd0);
    check_val({tag, "_ready"}, 32'(m_ir), 32'd1);
  endtask

  initial begin
    int n;
    int k;
    rst_n     = 1'b0;
    instr     = 16'h0000;
    res_ready = 1'b1;
    vld       = 1'b0;
    sel       = 1'b0;

    // Reset state
    #12;
    check_val("rst_res_valid", 32'(m_rv), 32'd0);
    check_val("rst_busy", 32'(m_busy), 32'd0);
    check_val("rst_alu_x", 32'(m_x), 32'h0);
    check_val("rst_alu_y", 32'(m_y), 32'h0);
    check_val("rst_alu_op", 32'(m_op), 32'h0);
    check_val("rst_alu_cin", 32'(m_cin), 32'h0);
    check_val("rst_res_data", 32'(m_rd), 32'h0);
    check_val("rst_res_cout", 32'(m_rc), 32'h0);
    check_val("rst_carry", 32'(m_cf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_instr_ready", 32'(m_ir), 32'd1);

    // Load: ADD r1,r0,#-1
    issue(16'h087F, n);
    check_val("load_latency", 32'(n), 32'd2);
    check_val("load_alu_x", 32'(m_x), 32'h0000);
    check_val("load_alu_y", 32'(m_y), 32'hFFFF);
    check_val("load_alu_op", 32'(m_op), 32'd0);
    check_val("load_alu_cin", 32'(m_cin), 32'd0);
    check_val("load_res_data", 32'(m_rd), 32'hFFFF);
    check_val("load_res_cout", 32'(m_rc), 32'd0);
    finish_wb("load");

    // Carry: ADD r2,r1,#1
    issue(16'h1241, n);
    check_val("carry_alu_x", 32'(m_x), 32'hFFFF);
    check_val("carry_alu_y", 32'(m_y), 32'h0001);
    check_val("carry_res_data", 32'(m_rd), 32'h0000);
    check_val("carry_res_cout", 32'(m_rc), 32'd1);
    check_val("carry_flag", 32'(m_cf), 32'd1);
    finish_wb("carry");

    // Non-add keeps carry: AND r3,r1,r2
    issue(16'h5B00, n);
    check_val("and_alu_op", 32'(m_op), 32'd2);
    check_val("and_alu_x", 32'(m_x), 32'hFFFF);
    check_val("and_alu_y", 32'(m_y), 32'h0000);
    check_val("and_alu_cin", 32'(m_cin), 32'd1);
    check_val("and_res_data", 32'(m_rd), 32'h0000);
    check_val("and_carry_kept", 32'(m_cf), 32'd1);
    finish_wb("and");

    // Backpressure: XOR r0,r1,#5 with res_ready low and instr_valid held
    @(negedge clk);
    res_ready = 1'b0;
    instr     = 16'h8245;
    vld       = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!m_rv && k < 20);
    check_val("bp_rv_rise", 32'(m_rv), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("bp_rv_hold", 32'(m_rv), 32'd1);
      check_val("bp_data_hold", 32'(m_rd), 32'hFFFA);
      check_val("bp_cout_hold", 32'(m_rc), 32'd0);
      check_val("bp_ready_low", 32'(m_ir), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_rv_drop", 32'(m_rv), 32'd0);
    check_val("bp_idle_ready", 32'(m_ir), 32'd1);
    check_val("bp_idle_busy", 32'(m_busy), 32'd0);
    @(posedge clk);
    #1;
    vld = 1'b0;
    check_val("bp_next_accept_busy", 32'(m_busy), 32'd1);
    check_val("bp_next_accept_ready", 32'(m_ir), 32'd0);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!m_rv && k < 20);
    check_val("bp_second_result", 32'(m_rd), 32'hFFFA);
    finish_wb("bp2");

    // Reset in the middle of EXEC: ADD r3,r1,#2 must never write back
    @(negedge clk);
    instr = 16'h1A42;
    vld   = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(m_busy), 32'd0);
    check_val("mid_rst_rv", 32'(m_rv), 32'd0);
    check_val("mid_rst_carry", 32'(m_cf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("post_rst_no_wb", 32'(m_rv), 32'd0);
    check_val("post_rst_idle", 32'(m_busy), 32'd0);
    // OR r0,r1,r3: both source registers must read back as zero
    issue(16'h6380, n);
    check_val("post_rst_r1", 32'(m_x), 32'h0000);
    check_val("post_rst_r3", 32'(m_y), 32'h0000);
    check_val("post_rst_cin", 32'(m_cin), 32'd0);
    check_val("post_rst_res", 32'(m_rd), 32'h0000);
    finish_wb("post_rst");

    // EXEC_WAIT=4 instance: Load scenario
    @(negedge clk);
    sel = 1'b1;
    issue(16'h087F, n);
    check_val("w4_latency", 32'(n), 32'd5);
    check_val("w4_alu_y", 32'(m_y), 32'hFFFF);
    check_val("w4_res_data", 32'(m_rd), 32'hFFFF);
    check_val("w4_res_cout", 32'(m_rc), 32'd0);
    finish_wb("w4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
